// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, keeps one imem request outstanding and holds the
// fetched instruction until execute consumes it. Define FETCH_TIMEOUT_EN for the ack watchdog.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_err
);

    localparam logic [31:0] NopInst = 32'h0000_0013;

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {StBoot, StReq, StOut, StHalt} state_e;

    localparam int unsigned CntW =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`else
    typedef enum logic [1:0] {StBoot, StReq, StOut} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        kill_q, kill_d;
    logic [31:0] tgt_q, tgt_d;

    logic [31:0] redir_pc;
    logic        ack;
    logic        unused_cfg;

    assign redir_pc = {redirect_target[31:2], 2'b00};
    // An ack is only meaningful against a live request.
    assign ack      = imem_ack & req_q;

`ifdef FETCH_TIMEOUT_EN
    assign unused_cfg = ^redirect_target[1:0];
`else
    assign unused_cfg = ^{redirect_target[1:0], TIMEOUT_CYCLES};
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_d     = req_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        kill_d    = kill_q;
        tgt_d     = tgt_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d     = '0;
        err_d     = err_q;
`endif

        unique case (state_q)
            StBoot: begin
                pc_d    = redirect_valid ? redir_pc : pc_q;
                req_d   = 1'b1;
                addr_d  = pc_d;
                state_d = StReq;
            end
            StReq: begin
                if (!req_q) begin
                    // Gap cycle after a killed fetch; a redirect here simply moves the reissue.
                    if (redirect_valid) begin
                        pc_d = redir_pc;
                    end
                    req_d  = 1'b1;
                    addr_d = pc_d;
                end else if (ack) begin
                    req_d = 1'b0;
                    if (kill_q || redirect_valid) begin
                        pc_d   = redirect_valid ? redir_pc : tgt_q;
                        kill_d = 1'b0;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        state_d   = StOut;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                    tgt_d  = redir_pc;
                end
`ifdef FETCH_TIMEOUT_EN
                if (!ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CntLimit) begin
                        err_d   = 1'b1;
                        req_d   = 1'b0;
                        valid_d = 1'b0;
                        state_d = StHalt;
                    end
                end
`endif
            end
            StOut: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    pc_d    = redir_pc;
                    req_d   = 1'b1;
                    addr_d  = redir_pc;
                    state_d = StReq;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    pc_d    = pc_q + 32'd4;
                    req_d   = 1'b1;
                    addr_d  = pc_d;
                    state_d = StReq;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            StHalt: begin
                state_d = StHalt;
            end
`endif
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StBoot;
            pc_q      <= RESET_PC;
            req_q     <= 1'b0;
            addr_q    <= RESET_PC;
            valid_q   <= 1'b0;
            inst_q    <= NopInst;
            inst_pc_q <= '0;
            kill_q    <= 1'b0;
            tgt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            kill_q    <= kill_d;
            tgt_q     <= tgt_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: scripted memory latency, scoreboard of expected request
// addresses and delivered instructions, one task per scenario.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC     = 32'h8000_0000;
    localparam int unsigned TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;
    int mem_delay = 1;          // negedges of wait before ack; negative = never ack
    logic [31:0] exp_addr_q[$]; // expected new-request addresses
    logic [31:0] exp_pc_q[$];   // expected delivered instruction PCs

    fetch_ctrl #(
        .RESET_PC      (RST_PC),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h0013_0000;
    endfunction

    // Memory model: acks mem_delay negedges after the request is first seen.
    initial begin
        int wait_cnt;
        wait_cnt   = 0;
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            if (imem_req === 1'b1 && mem_delay >= 0) begin
                if (wait_cnt >= mem_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    wait_cnt   = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard monitor: new requests and rising inst_valid are checked against the queues.
    initial begin
        logic        prev_req;
        logic        prev_valid;
        logic [31:0] prev_addr;
        logic [31:0] exp;
        prev_req   = 1'b0;
        prev_valid = 1'b0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (imem_req === 1'b1 && prev_req !== 1'b1) begin
                    total++;
                    if (exp_addr_q.size() == 0) begin
                        bad++;
                        $display("FAIL req_addr: got unexpected request at %h, required none",
                                 imem_addr);
                    end else begin
                        exp = exp_addr_q.pop_front();
                        if (imem_addr !== exp) begin
                            bad++;
                            $display("FAIL req_addr: got %h required %h", imem_addr, exp);
                        end
                    end
                end
                if (imem_req === 1'b1 && prev_req === 1'b1) begin
                    total++;
                    if (imem_addr !== prev_addr) begin
                        bad++;
                        $display("FAIL req_stable: got %h required %h", imem_addr, prev_addr);
                    end
                end
                if (inst_valid === 1'b1 && prev_valid !== 1'b1) begin
                    total++;
                    if (exp_pc_q.size() == 0) begin
                        bad++;
                        $display("FAIL inst_deliver: got unexpected pc %h, required none",
                                 inst_pc);
                    end else begin
                        exp = exp_pc_q.pop_front();
                        if (inst_pc !== exp || inst !== mem_word(exp)) begin
                            bad++;
                            $display("FAIL inst_deliver: got pc %h inst %h required pc %h inst %h",
                                     inst_pc, inst, exp, mem_word(exp));
                        end
                    end
                end
            end
            prev_req   = imem_req;
            prev_addr  = imem_addr;
            prev_valid = inst_valid;
        end
    end

    task automatic run_until_valid(input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (inst_valid === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        repeat (2) @(negedge clk);
        total++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC) begin
            bad++;
            $display("FAIL reset_req: got req=%b addr=%h required req=0 addr=%h",
                     imem_req, imem_addr, RST_PC);
        end
        total++;
        if (inst_valid !== 1'b0 || inst !== 32'h0000_0013 || inst_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_inst: got v=%b inst=%h pc=%h required v=0 inst=00000013 pc=0",
                     inst_valid, inst, inst_pc);
        end
        total++;
        if (fetch_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err: got %b required 0", fetch_err);
        end
    endtask

    task automatic test_sequential();
        bit hit;
        for (int i = 0; i < 3; i++) begin
            exp_addr_q.push_back(RST_PC + 32'(4 * i));
            exp_pc_q.push_back(RST_PC + 32'(4 * i));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_until_valid(20, hit);
            total++;
            if (!hit) begin
                bad++;
                $display("FAIL seq_timeout: got no inst_valid for fetch %0d, required one", i);
            end
            if (i == 2) begin
                stall = 1'b1;
            end else begin
                @(negedge clk);
                total++;
                if (inst_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL valid_pulse: got inst_valid=%b required 0", inst_valid);
                end
            end
        end
    endtask

    task automatic test_zero_wait();
        logic [3:0] req_seen;
        logic [3:0] val_seen;
        @(negedge clk);
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0008) begin
            bad++;
            $display("FAIL hold_before_zw: got v=%b pc=%h required v=1 pc=80000008",
                     inst_valid, inst_pc);
        end
        exp_addr_q.push_back(32'h8000_000C);
        exp_addr_q.push_back(32'h8000_0010);
        exp_pc_q.push_back(32'h8000_000C);
        exp_pc_q.push_back(32'h8000_0010);
        mem_delay = 0;
        stall     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_seen[3-i] = imem_req;
            val_seen[3-i] = inst_valid;
            if (i == 3) stall = 1'b1;
        end
        total++;
        if (req_seen !== 4'b1010 || val_seen !== 4'b0101) begin
            bad++;
            $display("FAIL zero_wait: got req=%b valid=%b required req=1010 valid=0101",
                     req_seen, val_seen);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0010 ||
                inst !== mem_word(32'h8000_0010) || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold: got v=%b pc=%h inst=%h req=%b required v=1 pc=%h inst=%h req=0",
                         inst_valid, inst_pc, inst, imem_req, 32'h8000_0010,
                         mem_word(32'h8000_0010));
            end
        end
        exp_addr_q.push_back(32'h8000_0014);
        mem_delay = 3;
        stall     = 1'b0;
    endtask

    task automatic test_redirect_pending();
        bit hit;
        bit found;
        bit saw_drop;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0014) begin
            bad++;
            $display("FAIL after_stall_addr: got req=%b addr=%h required req=1 addr=80000014",
                     imem_req, imem_addr);
        end
        redirect_valid  = 1'b1;
        redirect_target = 32'h8000_0102;
        exp_addr_q.push_back(32'h8000_0100);
        exp_pc_q.push_back(32'h8000_0100);
        found    = 1'b0;
        saw_drop = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            total++;
            if (inst_valid !== 1'b0) begin
                bad++;
                $display("FAIL kill_discard: got inst_valid=%b pc=%h required 0", inst_valid,
                         inst_pc);
            end
            if (imem_req === 1'b0) saw_drop = 1'b1;
            if (imem_req === 1'b1 && imem_addr === 32'h8000_0100) found = 1'b1;
        end
        total++;
        if (!found || !saw_drop) begin
            bad++;
            $display("FAIL kill_reissue: got found=%b drop=%b required found=1 drop=1",
                     found, saw_drop);
        end
        run_until_valid(20, hit);
        stall = 1'b1;
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL redirect_fetch: got no inst_valid, required one");
        end
    endtask

    task automatic test_double_redirect();
        bit hit;
        bit found;
        @(negedge clk);
        mem_delay = 4;
        stall     = 1'b0;
        exp_addr_q.push_back(32'h8000_0104);
        @(negedge clk);
        redirect_valid  = 1'b1;
        redirect_target = 32'h8000_0200;
        @(negedge clk);
        redirect_target = 32'h8000_0300;
        exp_addr_q.push_back(32'h8000_0300);
        exp_pc_q.push_back(32'h8000_0300);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            total++;
            if (inst_valid !== 1'b0 || (imem_req === 1'b1 && imem_addr === 32'h8000_0200)) begin
                bad++;
                $display("FAIL newest_wins: got v=%b req=%b addr=%h required v=0, no 80000200",
                         inst_valid, imem_req, imem_addr);
            end
            if (imem_req === 1'b1 && imem_addr === 32'h8000_0300) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL double_reissue: got no request at 80000300, required one");
        end
        run_until_valid(20, hit);
        mem_delay = 0;
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL double_fetch: got no inst_valid, required one");
        end
        // Redirect coinciding with a zero-wait ack of the next sequential fetch.
        exp_addr_q.push_back(32'h8000_0304);
        exp_addr_q.push_back(32'h8000_0400);
        exp_pc_q.push_back(32'h8000_0400);
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0304) begin
            bad++;
            $display("FAIL ack_redir_req: got req=%b addr=%h required req=1 addr=80000304",
                     imem_req, imem_addr);
        end
        redirect_valid  = 1'b1;
        redirect_target = 32'h8000_0400;
        @(negedge clk);
        redirect_valid = 1'b0;
        total++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL ack_redir_drop: got v=%b req=%b required v=0 req=0",
                     inst_valid, imem_req);
        end
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0400 || inst_valid !== 1'b0) begin
            bad++;
            $display("FAIL ack_redir_reissue: got req=%b addr=%h v=%b required req=1 addr=80000400 v=0",
                     imem_req, imem_addr, inst_valid);
        end
        @(negedge clk);
        stall = 1'b1;
        total++;
        if (inst_valid !== 1'b1) begin
            bad++;
            $display("FAIL ack_redir_fetch: got inst_valid=%b required 1", inst_valid);
        end
    endtask

    task automatic test_wrap_redirect_out();
        @(negedge clk);
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0000_0000);
        exp_pc_q.push_back(32'hFFFF_FFFC);
        exp_pc_q.push_back(32'h0000_0000);
        @(negedge clk);
        redirect_valid = 1'b0;
        total++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL redir_out_stalled: got v=%b req=%b addr=%h required v=0 req=1 addr=fffffffc",
                     inst_valid, imem_req, imem_addr);
        end
        @(negedge clk);
        stall = 1'b0;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
            bad++;
            $display("FAIL pc_wrap: got req=%b addr=%h required req=1 addr=00000000",
                     imem_req, imem_addr);
        end
        @(negedge clk);
        stall = 1'b1;
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_0000) begin
            bad++;
            $display("FAIL wrap_fetch: got v=%b pc=%h required v=1 pc=00000000",
                     inst_valid, inst_pc);
        end
    endtask

    task automatic test_boot_redirect();
        bit hit;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC || inst_valid !== 1'b0 ||
            inst !== 32'h0000_0013 || inst_pc !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: got req=%b addr=%h v=%b inst=%h pc=%h required reset values",
                     imem_req, imem_addr, inst_valid, inst, inst_pc);
        end
        @(negedge clk);
        exp_addr_q.push_back(32'h9000_0040);
        exp_pc_q.push_back(32'h9000_0040);
        rst_n           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h9000_0041;
        @(negedge clk);
        redirect_valid = 1'b0;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h9000_0040) begin
            bad++;
            $display("FAIL boot_redirect: got req=%b addr=%h required req=1 addr=90000040",
                     imem_req, imem_addr);
        end
        run_until_valid(10, hit);
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL boot_fetch: got no inst_valid, required one");
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        mem_delay = -1;
        stall     = 1'b0;
        exp_addr_q.push_back(32'h9000_0044);
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (i < 4) begin
                if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
                    bad++;
                    $display("FAIL timeout_wait: cycle %0d got err=%b req=%b required err=0 req=1",
                             i, fetch_err, imem_req);
                end
            end else if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                bad++;
                $display("FAIL timeout_halt: got err=%b req=%b v=%b required err=1 req=0 v=0",
                         fetch_err, imem_req, inst_valid);
            end
        end
        redirect_valid  = 1'b1;
        redirect_target = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                bad++;
                $display("FAIL halt_sticky: got err=%b req=%b v=%b required err=1 req=0 v=0",
                         fetch_err, imem_req, inst_valid);
            end
        end
        redirect_valid = 1'b0;
`else
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
                bad++;
                $display("FAIL no_timeout: cycle %0d got err=%b req=%b required err=0 req=1",
                         i, fetch_err, imem_req);
            end
        end
`endif
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b0 || imem_addr !== RST_PC ||
            inst_valid !== 1'b0 || inst !== 32'h0000_0013 || inst_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_from_wait: got err=%b req=%b addr=%h v=%b inst=%h pc=%h required reset values",
                     fetch_err, imem_req, imem_addr, inst_valid, inst, inst_pc);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_zero_wait();
        test_stall();
        test_redirect_pending();
        test_double_redirect();
        test_wrap_redirect_out();
        test_boot_redirect();
        test_timeout();
        repeat (2) @(negedge clk);
        total++;
        if (exp_addr_q.size() != 0 || exp_pc_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d addr and %0d inst left, required 0 and 0",
                     exp_addr_q.size(), exp_pc_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
